fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline, sitting directly upstream of the decode-stage control unit. It owns the PC and issues requests to instruction memory over a req/ack handshake. It presents the fetched instruction and PC+4 to decode, and honours stall, flush, taken-branch redirect and halt from downstream. A one-entry skid buffer keeps an instruction that arrives during a stall, so it is not fetched twice.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding placed in IF/ID when it is empty or flushed; decodes as nop in the control unit.
- clk  in  1  single pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_Req  out  1  instruction-memory request.
- imem_Addr  out  32  fetch address; always equals PC.
- imem_Ack  in  1  request accepted; data valid in the same cycle.
- imem_Data  in  32  fetched instruction.
- stall  in  1  hold IF/ID and PC; same source as the control unit's injectNop.
- id_Flush  in  1  clear IF/ID at the next edge (from control unit).
- branchTaken  in  1  redirect fetch.
- branchTarget  in  32  redirect address, valid with branchTaken.
- halt  in  1  halt decoded in ID (from control unit).
- id_Instr  out  32  IF/ID instruction.
- id_PcPlus4  out  32  IF/ID PC+4 of that instruction.
- id_Valid  out  1  IF/ID holds a real fetched instruction.
- halted  out  1  stage is in the HALTED state.

## Operation
- States:
  - RUN: normal fetch.
  - DRAIN: redirect pending while a request is still un-acked.
  - HALTED: terminal until reset.
- imem_Req is 1 when in RUN and (skid buffer empty or stall == 0); otherwise 0.
- imem_Addr must stay stable while imem_Req is high and imem_Ack is low.
- Accepted fetch = imem_Req & imem_Ack at an edge. On an accepted fetch, PC ← PC+4 (mod 2^32, wraps).
- Priority at each edge: branchTaken > halt > id_Flush > stall > normal.
- branchTaken:
  - IF/ID ← {NOP_INSTR, 0, valid=0}; skid cleared; any accepted data is discarded.
  - If a request is outstanding and un-acked, the target is stored and the state goes to DRAIN. In DRAIN, imem_Addr stays at the old PC and imem_Req stays 1.
  - The first ack in DRAIN is discarded; PC ← stored target; state → RUN.
  - Otherwise PC ← branchTarget immediately.
- halt without branchTaken: IF/ID ← NOP with valid=0, skid cleared, PC frozen, state → HALTED. In HALTED, imem_Req=0 and halted=1.
- id_Flush only: IF/ID ← NOP with valid=0. An accepted fetch in the same cycle loads the skid buffer instead, and PC advances.
- stall:
  - IF/ID holds its value.
  - An accepted fetch goes into the empty skid buffer.
  - While stalled with the skid buffer full, imem_Req=0.
- Normal (no stall, no flush):
  - If the skid buffer is full: IF/ID ← skid contents. If a fetch is accepted in the same edge, its data refills the skid buffer.
  - Else if a fetch is accepted: IF/ID ← {imem_Data, PC+4, 1}.
  - Else: IF/ID ← NOP with valid=0 (bubble).

## Timing
- Reset values (asynchronous, while rst_n=0):
  - PC=RESET_PC; state=RUN; skid buffer empty.
  - id_Instr=NOP_INSTR, id_PcPlus4=0, id_Valid=0, halted=0.
  - imem_Req=0.
- imem_Req rises in the first cycle after rst_n deasserts.
- Zero-wait memory (imem_Ack tied 1): address in cycle N → IF/ID valid in cycle N+1, one instruction per cycle.
- Redirect asserted in cycle N with no outstanding request: imem_Addr=branchTarget in cycle N+1, and the target instruction reaches IF/ID in N+2.
- Redirect with a W-cycle wait state: the target address is issued in the cycle after the drained ack.
- Stall release with the skid buffer full: the skid instruction reaches IF/ID at the first non-stalled edge, with no bubble.
- Reset asserted mid-request, mid-DRAIN or in HALTED returns immediately to the reset values. A late imem_Ack during reset is ignored.

## Structure
- Shared defs file holds:
  - INSTR_SIZE (32) and NOP_INSTR encoding, shared with the control unit.
  - Fetch state encodings RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
- One sub-module: fetch_skid, a one-entry {instr, pcPlus4} buffer with load/unload/clear and a full flag.
- PC logic, the state machine and the IF/ID register stay in fetch_stage.

## Test plan
- Reset, ack tied 1, 4 cycles → imem_Addr 0,4,8,12; id_PcPlus4 4,8,12 with id_Valid=1 from the second cycle.
- Ack delayed 2 cycles per request → id_Valid=1 only every third cycle; imem_Addr stable while waiting.
- Stall for 3 cycles while an ack arrives → IF/ID unchanged, skid full, imem_Req=0. On release the skid instruction enters IF/ID, PC has advanced by 4 only, no instruction is lost or duplicated.
- branchTaken with target 32'h40 while a request is un-acked → DRAIN. The drained data never appears in IF/ID; the next imem_Addr=32'h40; IF/ID shows NOP with valid=0 in between.
- halt pulse → halted=1 and imem_Req=0 forever. A simultaneous halt+branchTaken instead redirects and halted stays 0.
- rst_n pulsed low while in HALTED → PC=RESET_PC, halted=0, fetching resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch definitions: instruction width, nop encoding, fetch states, IF/ID layout.
package fetch_stage_pkg;

  localparam int                    INSTR_SIZE = 32;
  localparam logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_SIZE-1:0] instr;
    logic [31:0]           pc_plus4;
    logic                  valid;
  } ifid_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake plus the IF/ID and downstream control signals.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                  imem_Req;
  logic [31:0]           imem_Addr;
  logic                  imem_Ack;
  logic [INSTR_SIZE-1:0] imem_Data;
  logic                  stall;
  logic                  id_Flush;
  logic                  branchTaken;
  logic [31:0]           branchTarget;
  logic                  halt;
  logic [INSTR_SIZE-1:0] id_Instr;
  logic [31:0]           id_PcPlus4;
  logic                  id_Valid;
  logic                  halted;

  modport master (
    output imem_Req, imem_Addr, id_Instr, id_PcPlus4, id_Valid, halted,
    input  imem_Ack, imem_Data, stall, id_Flush, branchTaken, branchTarget, halt
  );

  modport slave (
    input  imem_Req, imem_Addr, id_Instr, id_PcPlus4, id_Valid, halted,
    output imem_Ack, imem_Data, stall, id_Flush, branchTaken, branchTarget, halt
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {instr, pcPlus4} holding buffer for a fetch accepted while IF/ID cannot take it.
// Clear wins over load, load wins over unload (a simultaneous load+unload refills the entry).
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_unload,
  input  logic                  i_clear,
  input  logic [INSTR_SIZE-1:0] i_instr,
  input  logic [31:0]           i_pc_plus4,
  output logic                  o_full,
  output logic [INSTR_SIZE-1:0] o_instr,
  output logic [31:0]           o_pc_plus4
);

  logic                  r_full;
  logic [INSTR_SIZE-1:0] r_instr;
  logic [31:0]           r_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full     <= 1'b1;
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full     = r_full;
  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch + IF/ID register: owns the PC, fetches over req/ack, handles
// stall/flush/redirect/halt, and parks a fetch that lands during a stall in a skid entry.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_target, w_target_nxt;
  ifid_t        r_ifid, w_ifid_nxt;

  logic                  w_req, w_acc;
  logic [31:0]           w_pc_plus4;
  logic                  w_skid_full, w_skid_load, w_skid_unload, w_skid_clear;
  logic [INSTR_SIZE-1:0] w_skid_instr;
  logic [31:0]           w_skid_pc_plus4;

  // Gated by rst_n so no request is visible while reset is held.
  assign w_req = rst_n &&
                 (((r_state == RUN) && (!w_skid_full || !bus.stall)) || (r_state == DRAIN));
  assign w_acc      = w_req & bus.imem_Ack;
  assign w_pc_plus4 = pc_inc(r_pc);

  fetch_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_skid_load),
    .i_unload   (w_skid_unload),
    .i_clear    (w_skid_clear),
    .i_instr    (bus.imem_Data),
    .i_pc_plus4 (w_pc_plus4),
    .o_full     (w_skid_full),
    .o_instr    (w_skid_instr),
    .o_pc_plus4 (w_skid_pc_plus4)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_target_nxt  = r_target;
    w_ifid_nxt    = r_ifid;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;
    if (r_state != HALTED) begin
      if (bus.branchTaken) begin
        w_ifid_nxt   = BUBBLE;
        w_skid_clear = 1'b1;
        // An un-acked request must complete at its old address before the target goes out.
        if (w_req && !bus.imem_Ack) begin
          w_target_nxt = bus.branchTarget;
          w_state_nxt  = DRAIN;
        end else begin
          w_pc_nxt    = bus.branchTarget;
          w_state_nxt = RUN;
        end
      end else if (bus.halt) begin
        w_ifid_nxt   = BUBBLE;
        w_skid_clear = 1'b1;
        w_state_nxt  = HALTED;
      end else if (r_state == DRAIN) begin
        if (w_acc) begin
          w_pc_nxt    = r_target;
          w_state_nxt = RUN;
        end
        if (bus.id_Flush || !bus.stall) w_ifid_nxt = BUBBLE;
      end else begin
        if (w_acc) w_pc_nxt = w_pc_plus4;
        if (bus.id_Flush) begin
          w_ifid_nxt  = BUBBLE;
          w_skid_load = w_acc;
        end else if (bus.stall) begin
          w_skid_load = w_acc;
        end else if (w_skid_full) begin
          w_ifid_nxt    = '{instr: w_skid_instr, pc_plus4: w_skid_pc_plus4, valid: 1'b1};
          w_skid_load   = w_acc;
          w_skid_unload = !w_acc;
        end else if (w_acc) begin
          w_ifid_nxt = '{instr: bus.imem_Data, pc_plus4: w_pc_plus4, valid: 1'b1};
        end else begin
          w_ifid_nxt = BUBBLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_target <= 32'd0;
      r_ifid   <= BUBBLE;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
      r_ifid   <= w_ifid_nxt;
    end
  end

  assign bus.imem_Req   = w_req;
  assign bus.imem_Addr  = r_pc;
  assign bus.id_Instr   = r_ifid.instr;
  assign bus.id_PcPlus4 = r_ifid.pc_plus4;
  assign bus.id_Valid   = r_ifid.valid;
  assign bus.halted     = (r_state == HALTED);

endmodule
